// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI-mode responder.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    HUNT,
    SHIFT,
    DECODE,
    DELAY,
    RESPOND
  } link_state_t;

  typedef enum logic [1:0] {
    PWRUP,
    IDLE,
    READY
  } card_state_t;

  localparam logic [5:0] CMD_GO_IDLE     = 6'd0;
  localparam logic [5:0] CMD_APP         = 6'd55;
  localparam logic [5:0] ACMD_SD_OP_COND = 6'd41;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clk, MSB-first data.
// clear together with en restarts the CRC from zero with din as first bit.
module sd_crc7 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // CRC shift register, advanced once per sampled command bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      crc <= '0;
    else if (en)
      crc <= crc7_step(clear ? 7'd0 : crc, din);
    else if (clear)
      crc <= '0;
  end

endmodule

// File: rtl/sd_spi_card_responder.sv
// SD-card SPI-mode responder: receives 48-bit command frames on MOSI,
// decodes CMD0 / CMD55 / ACMD41, tracks the card power-up state and answers
// with an R1 byte on MISO. Define SD_RSP_CRC7_CHECK_EN to verify the CRC7
// field of each frame; by default the CRC field is ignored.
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter int INIT_RETRIES = 2,
  parameter int NCR_BITS     = 0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rising_edge_sclk,
  input  logic        falling_edge_sclk,
  input  logic        spi_cs,
  input  logic        mosi,
  output logic        miso,
  output logic        card_ready,
  output logic        cmd_strobe,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg
);

  localparam int CNT_W = $clog2(INIT_RETRIES + 1);
  localparam logic [CNT_W-1:0] LAST_RETRY = CNT_W'(INIT_RETRIES - 1);
  localparam logic [3:0] NCR_LAST = 4'(NCR_BITS - 1);
  localparam bit HAS_NCR = (NCR_BITS > 0);

  link_state_t link_state, link_next;
  card_state_t card_state, card_next;

  logic [5:0]       bit_cnt;
  logic [45:0]      frame;
  logic [3:0]       dly_cnt;
  logic [2:0]       rsp_cnt;
  logic             rsp_done;
  logic [7:0]       r1, r1_next;
  logic             app_cmd, app_next;
  logic [CNT_W-1:0] acmd41_cnt, cnt_next;
  logic             ready_next;
  logic             idle_bit;

  logic       rise, fall;
  logic       start_bit, shift_bit, decode_en, pwrup_drop, crc_ok;
  logic [5:0] frame_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // A rising strobe wins over a coincident falling strobe
  assign rise = rising_edge_sclk;
  assign fall = falling_edge_sclk & ~rising_edge_sclk;

  assign frame_idx  = frame[45:40];
  assign start_bit  = ~spi_cs & (link_state == HUNT) & rise & ~mosi;
  assign shift_bit  = ~spi_cs & (link_state == SHIFT) & rise;
  assign decode_en  = ~spi_cs & (link_state == DECODE) & frame[0];
  assign pwrup_drop = (card_state == PWRUP) && (frame_idx != CMD_GO_IDLE);

`ifdef SD_RSP_CRC7_CHECK_EN
  logic [6:0] crc_calc;
  logic       crc_en;

  // CRC covers the start bit plus the next 39 bits (frame bits 47..8)
  assign crc_en = start_bit | (shift_bit & (bit_cnt < 6'd40));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (start_bit),
    .en    (crc_en),
    .din   (mosi),
    .crc   (crc_calc)
  );

  assign crc_ok = (crc_calc == frame[7:1]);
`else
  logic unused_crc_bits;
  assign unused_crc_bits = ^frame[7:1];
  assign crc_ok = 1'b1;
`endif

  // Link FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      link_state <= HUNT;
    else
      link_state <= link_next;
  end

  // Link FSM next-state logic; chip-select release always forces HUNT
  always_comb begin
    link_next = link_state;
    if (spi_cs) begin
      link_next = HUNT;
    end else begin
      unique case (link_state)
        HUNT:    if (rise && !mosi) link_next = SHIFT;
        SHIFT: begin
          if (rise) begin
            if (bit_cnt == 6'd1 && !mosi) link_next = HUNT;
            else if (bit_cnt == 6'd47)    link_next = DECODE;
          end
        end
        DECODE: begin
          if (!frame[0] || pwrup_drop) link_next = HUNT;
          else if (HAS_NCR)            link_next = DELAY;
          else                         link_next = RESPOND;
        end
        DELAY:   if (fall && dly_cnt == NCR_LAST) link_next = RESPOND;
        RESPOND: if (fall && rsp_done)            link_next = HUNT;
        default: link_next = HUNT;
      endcase
    end
  end

  // Command bit counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      bit_cnt <= '0;
    else if (start_bit)
      bit_cnt <= 6'd1;
    else if (shift_bit)
      bit_cnt <= bit_cnt + 6'd1;
  end

  // Frame shift register; start and transmission bits fall off the top
  always_ff @(posedge clk) begin
    if (start_bit || shift_bit)
      frame <= {frame[44:0], mosi};
  end

  // Card-state update computed from the captured frame
  always_comb begin
    idle_bit   = (card_state == IDLE);
    r1_next    = 8'h00;
    card_next  = card_state;
    app_next   = 1'b0;
    cnt_next   = acmd41_cnt;
    ready_next = card_ready;
    r1_next[R1_IDLE] = idle_bit;
    if (!crc_ok) begin
      r1_next[R1_CRC_ERR] = 1'b1;
      app_next = app_cmd;
    end else if (frame_idx == CMD_GO_IDLE) begin
      card_next  = IDLE;
      cnt_next   = '0;
      ready_next = 1'b0;
      r1_next    = 8'h01;
    end else if (frame_idx == CMD_APP) begin
      app_next = 1'b1;
    end else if (frame_idx == ACMD_SD_OP_COND && app_cmd) begin
      if (card_state == IDLE) begin
        if (acmd41_cnt < LAST_RETRY) begin
          cnt_next = sat_inc(acmd41_cnt);
        end else begin
          card_next  = READY;
          ready_next = 1'b1;
          r1_next    = 8'h00;
        end
      end
    end else begin
      r1_next[R1_ILLEGAL] = 1'b1;
    end
  end

  // Command outputs and card-state registers, loaded in the DECODE clk
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      card_state <= PWRUP;
      app_cmd    <= 1'b0;
      acmd41_cnt <= '0;
      card_ready <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_index  <= '0;
      cmd_arg    <= '0;
    end else begin
      cmd_strobe <= 1'b0;
      if (decode_en) begin
        cmd_strobe <= 1'b1;
        cmd_index  <= frame_idx;
        cmd_arg    <= frame[39:8];
        if (!pwrup_drop) begin
          card_state <= card_next;
          app_cmd    <= app_next;
          acmd41_cnt <= cnt_next;
          card_ready <= ready_next;
        end
      end
    end
  end

  // Latched response byte
  always_ff @(posedge clk) begin
    if (decode_en)
      r1 <= r1_next;
  end

  // MISO driver: NCR filler, then R1 MSB first, then back to idle-high
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      miso     <= 1'b1;
      dly_cnt  <= '0;
      rsp_cnt  <= '0;
      rsp_done <= 1'b0;
    end else if (spi_cs) begin
      miso <= 1'b1;
    end else begin
      unique case (link_state)
        DECODE: begin
          miso     <= 1'b1;
          dly_cnt  <= '0;
          rsp_cnt  <= '0;
          rsp_done <= 1'b0;
        end
        DELAY: if (fall) dly_cnt <= dly_cnt + 4'd1;
        RESPOND: begin
          if (fall) begin
            if (rsp_done) begin
              miso <= 1'b1;
            end else begin
              miso    <= r1[3'd7 - rsp_cnt];
              rsp_cnt <= rsp_cnt + 3'd1;
              if (rsp_cnt == 3'd7) rsp_done <= 1'b1;
            end
          end
        end
        default: miso <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Self-checking bench for sd_spi_card_responder. Two instances share the
// stimulus: one with NCR_BITS=0 and one with NCR_BITS=3.
module tb_sd_spi_card_responder;

  logic clk = 1'b0;
  logic n_rst, rise, fall, cs, mosi;

  logic        miso0, ready0, strobe0;
  logic [5:0]  idx0;
  logic [31:0] arg0;
  logic        miso3, ready3, strobe3;
  logic [5:0]  idx3;
  logic [31:0] arg3;

  always #5 clk = ~clk;

  sd_spi_card_responder #(.INIT_RETRIES(2), .NCR_BITS(0)) dut (
    .clk(clk), .n_rst(n_rst), .rising_edge_sclk(rise), .falling_edge_sclk(fall),
    .spi_cs(cs), .mosi(mosi), .miso(miso0), .card_ready(ready0),
    .cmd_strobe(strobe0), .cmd_index(idx0), .cmd_arg(arg0)
  );

  sd_spi_card_responder #(.INIT_RETRIES(2), .NCR_BITS(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .rising_edge_sclk(rise), .falling_edge_sclk(fall),
    .spi_cs(cs), .mosi(mosi), .miso(miso3), .card_ready(ready3),
    .cmd_strobe(strobe3), .cmd_index(idx3), .cmd_arg(arg3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int strb0 = 0;
  int strb3 = 0;
  logic [5:0]  seen_idx;
  logic [31:0] seen_arg;

  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [47:0] frame;
    logic [7:0]  r1;
    logic        stb;
    logic        rdy;
  } vec_t;

  vec_t tbl[19];

  localparam logic [47:0] C0     = 48'h400000000095;
  localparam logic [47:0] C55    = 48'h770000000065;
  localparam logic [47:0] A41    = 48'h69001000005F;
  localparam logic [47:0] BADEND = 48'h400000000094;
  localparam logic [47:0] BADTX  = 48'h3FFFFFFFFFFF;

  // Count command strobes away from the active edge
  always @(negedge clk) begin
    if (strobe0) begin
      strb0    <= strb0 + 1;
      seen_idx <= idx0;
      seen_arg <= arg0;
    end
    if (strobe3) strb3 <= strb3 + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One SCLK period: rising strobe (host samples MISO), then falling strobe
  task automatic sclk_bit(input logic b, output logic m0, output logic m3);
    @(negedge clk);
    mosi = b;
    rise = 1'b1;
    m0 = miso0;
    m3 = miso3;
    @(negedge clk);
    rise = 1'b0;
    @(negedge clk);
    fall = 1'b1;
    @(negedge clk);
    fall = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [47:0] f, input logic [7:0] exp_r1,
                           input logic exp_stb, input logic exp_rdy);
    int s0, s3;
    logic m0, m3, quiet;
    logic [8:0]  w0;
    logic [11:0] w3;
    logic [7:0]  e;
    exp_q.push_back(exp_r1);
    s0 = strb0;
    s3 = strb3;
    quiet = 1'b1;
    w0 = '0;
    w3 = '0;
    for (int i = 47; i >= 0; i--) begin
      sclk_bit(f[i], m0, m3);
      quiet = quiet & m0 & m3;
    end
    for (int i = 0; i < 12; i++) begin
      sclk_bit(1'b1, m0, m3);
      if (i < 9) w0 = {w0[7:0], m0};
      w3 = {w3[10:0], m3};
    end
    e = exp_q.pop_front();
    check({name, " miso ncr0"}, 64'(w0), 64'({e, 1'b1}));
    check({name, " miso ncr3"}, 64'(w3), 64'({3'b111, e, 1'b1}));
    check({name, " miso idle during cmd"}, 64'(quiet), 64'(1));
    check({name, " strobe ncr0"}, 64'(strb0 - s0), 64'(exp_stb));
    check({name, " strobe ncr3"}, 64'(strb3 - s3), 64'(exp_stb));
    if (exp_stb) begin
      check({name, " cmd_index"}, 64'(seen_idx), 64'(f[45:40]));
      check({name, " cmd_arg"}, 64'(seen_arg), 64'(f[39:8]));
    end
    check({name, " card_ready ncr0"}, 64'(ready0), 64'(exp_rdy));
    check({name, " card_ready ncr3"}, 64'(ready3), 64'(exp_rdy));
  endtask

  initial begin
    logic m0, m3, ones;
    int s0;

    tbl[0]  = '{C0,     8'h01, 1'b1, 1'b0};
    tbl[1]  = '{BADEND, 8'hFF, 1'b0, 1'b0};
    tbl[2]  = '{BADTX,  8'hFF, 1'b0, 1'b0};
    tbl[3]  = '{C55,    8'h01, 1'b1, 1'b0};
    tbl[4]  = '{A41,    8'h01, 1'b1, 1'b0};
    tbl[5]  = '{C55,    8'h01, 1'b1, 1'b0};
    tbl[6]  = '{A41,    8'h00, 1'b1, 1'b1};
    tbl[7]  = '{C55,    8'h00, 1'b1, 1'b1};
    tbl[8]  = '{A41,    8'h00, 1'b1, 1'b1};
    tbl[9]  = '{A41,    8'h04, 1'b1, 1'b1};
    tbl[10] = '{C0,     8'h01, 1'b1, 1'b0};
    tbl[11] = '{A41,    8'h05, 1'b1, 1'b0};
    tbl[12] = '{C55,    8'h01, 1'b1, 1'b0};
    tbl[13] = '{C0,     8'h01, 1'b1, 1'b0};
    tbl[14] = '{A41,    8'h05, 1'b1, 1'b0};
    tbl[15] = '{C55,    8'h01, 1'b1, 1'b0};
    tbl[16] = '{A41,    8'h01, 1'b1, 1'b0};
    tbl[17] = '{C55,    8'h01, 1'b1, 1'b0};
    tbl[18] = '{A41,    8'h00, 1'b1, 1'b1};

    n_rst = 1'b0;
    cs    = 1'b1;
    rise  = 1'b0;
    fall  = 1'b0;
    mosi  = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    check("reset miso", 64'(miso0), 64'(1));
    check("reset card_ready", 64'(ready0), 64'(0));
    check("reset cmd_strobe", 64'(strobe0), 64'(0));
    check("reset cmd_index", 64'(idx0), 64'(0));
    check("reset cmd_arg", 64'(arg0), 64'(0));

    // Deselected traffic that would form a valid frame if CS were ignored
    ones = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sclk_bit(i[0], m0, m3);
      ones = ones & m0 & m3;
    end
    check("deselected miso", 64'(ones), 64'(1));
    check("deselected strobes", 64'(strb0 + strb3), 64'(0));
    check("deselected card_ready", 64'(ready0), 64'(0));

    // CS released at bit 20 of a CMD0
    cs = 1'b0;
    s0 = strb0;
    for (int i = 47; i > 27; i--) sclk_bit(C0[i], m0, m3);
    cs = 1'b1;
    ones = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk_bit(1'b1, m0, m3);
      ones = ones & m0 & m3;
    end
    cs = 1'b0;
    check("abort miso", 64'(ones), 64'(1));
    check("abort strobe", 64'(strb0 - s0), 64'(0));

    run_frame("pwrup cmd55", C55, 8'hFF, 1'b1, 1'b0);
`ifdef SD_RSP_CRC7_CHECK_EN
    run_frame("cmd0 bad crc", 48'h400000000097, 8'h08, 1'b1, 1'b0);
`else
    run_frame("cmd0 bad crc", 48'h400000000097, 8'h01, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 19; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].frame, tbl[i].r1, tbl[i].stb, tbl[i].rdy);

    // CS release mid-frame in READY leaves the card state alone
    for (int i = 47; i > 27; i--) sclk_bit(C0[i], m0, m3);
    cs = 1'b1;
    sclk_bit(1'b1, m0, m3);
    cs = 1'b0;
    check("abort ready kept", 64'(ready0), 64'(1));
    run_frame("post-abort cmd55", C55, 8'h00, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
